id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   Pipeline boundary between decode (register-file read) and execute. Captures operands,
//   immediate, rd and control into the ID/EX register. Bypasses same-cycle write-back data
//   around the register file. Detects load-use hazards and requests a one-cycle IF/ID stall.
//   Accepts a branch flush from EX/MEM. Keeps stall and flush event counters.
// PARAMETERS
//   XLEN    64  datapath / operand width
//   CTRL_W   8  control bundle {RegWrite,MemRead,MemWrite,Branch,ALUSrc,MemtoReg,ALUOp[1:0]}
//   CNT_W   32  width of each event counter
// PORTS
//   clk           in   1       rising-edge clock
//   reset         in   1       asynchronous, active-low reset
//   id_valid      in   1       decode stage holds a real instruction
//   id_pc         in   XLEN    PC of decode instruction
//   id_rs1        in   5       source register 1 index
//   id_rs2        in   5       source register 2 index
//   id_rd         in   5       destination register index
//   id_imm        in   XLEN    sign-extended immediate
//   id_ctrl       in   CTRL_W  decoded control bundle (bit 6 = MemRead, bit 7 = RegWrite)
//   ReadData1     in   XLEN    register file port 1 data
//   ReadData2     in   XLEN    register file port 2 data
//   wb_regwrite   in   1       write-back stage writes register file this cycle
//   wb_rd         in   5       write-back destination index
//   wb_data       in   XLEN    write-back data
//   flush         in   1       branch taken in EX/MEM; kill instruction entering EX
//   stall         out  1       hold PC and IF/ID this cycle (combinational)
//   ex_valid      out  1       ID/EX holds a real instruction
//   ex_pc         out  XLEN    registered PC
//   ex_op1        out  XLEN    registered operand 1
//   ex_op2        out  XLEN    registered operand 2
//   ex_imm        out  XLEN    registered immediate
//   ex_rs1        out  5       registered rs1 (for EX forwarding unit)
//   ex_rs2        out  5       registered rs2
//   ex_rd         out  5       registered rd
//   ex_ctrl       out  CTRL_W  registered control; all-zero for a bubble
//   stall_count   out  CNT_W   number of stall cycles since reset, saturating
//   flush_count   out  CNT_W   number of flush cycles since reset, saturating
// BEHAVIOUR
//   - Reset (reset==0, async):
//     - All registered outputs are 0, including ex_valid, ex_ctrl and both counters.
//     - Reset mid-operation discards the in-flight instruction immediately.
//   - Operand select (combinational):
//     - op1 = 0 if id_rs1==0.
//     - Otherwise op1 = wb_data if wb_regwrite && wb_rd!=0 && wb_rd==id_rs1.
//     - Otherwise op1 = ReadData1.
//     - op2 is selected identically from id_rs2, wb_* and ReadData2.
//   - Hazard (combinational):
//     - haz = ex_valid && ex_ctrl[6] && ex_rd!=0 && id_valid
//             && (ex_rd==id_rs1 || ex_rd==id_rs2).
//     - stall = haz && !flush.
//   - Each posedge, priority is flush > stall > advance:
//     - flush: load a bubble (ex_valid=0, ex_ctrl=0, other fields 0);
//       flush_count++.
//     - stall: load a bubble; stall_count++. The decode instruction is held
//       upstream and re-presented the next cycle.
//     - advance: ex_* <= id_* and the selected operands; ex_valid <= id_valid.
//       If id_valid==0, ex_ctrl <= 0.
//   - Latency: one cycle decode->EX. A stall costs exactly one bubble, because the next
//     cycle ex_valid=0 and haz deasserts.
//   - Counters saturate at all-ones and do not wrap.
//   - Write-back to x0 is never bypassed. x0 always reads as 0.
//   - A bubble never asserts RegWrite, MemRead or MemWrite downstream.
// TESTING
//   1. Reset: drive reset=0 mid-run with ex_valid=1 -> all outputs 0 before the next
//      clock edge; counters = 0.
//   2. Advance: id_rs1=5 (RD1=0x10), id_rs2=6 (RD2=0x20), imm=-4, ctrl=0x80, no wb
//      -> next cycle ex_op1=0x10, ex_op2=0x20, ex_imm=0xFFFF_FFFF_FFFF_FFFC,
//      ex_valid=1.
//   3. WB bypass: wb_regwrite=1, wb_rd=5, wb_data=0xAB, id_rs1=5, RD1=0x10
//      -> ex_op1=0xAB. Repeat with wb_rd=0 and id_rs1=0 -> ex_op1=0.
//   4. Load-use: ex holds ld x7 (ctrl[6]=1, rd=7); id_rs2=7 -> stall=1 for exactly one
//      cycle; bubble with ex_ctrl=0; stall_count=1; the instruction advances next cycle.
//   5. Flush vs stall: load-use hazard present and flush=1 in the same cycle -> stall=0,
//      bubble loaded, flush_count=1, stall_count unchanged.
//   6. Saturation: force flush_count to all-ones, assert flush -> count stays
//      0xFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Interface for the ID/EX boundary: decode-side inputs, write-back bypass,
// branch flush, and the registered EX-side outputs with event counters.
interface id_ex_stage_if #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   ReadData1;
    logic [XLEN-1:0]   ReadData2;
    logic              wb_regwrite;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
               ReadData1, ReadData2, wb_regwrite, wb_rd, wb_data, flush,
        input  stall, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1,
               ex_rs2, ex_rd, ex_ctrl, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
               ReadData1, ReadData2, wb_regwrite, wb_rd, wb_data, flush,
        output stall, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1,
               ex_rs2, ex_rd, ex_ctrl, stall_count, flush_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use stall detection,
// branch flush and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam int CTRL_MEMREAD = 6;

    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q,    ex_pc_d;
    logic [XLEN-1:0]   ex_op1_q,   ex_op1_d;
    logic [XLEN-1:0]   ex_op2_q,   ex_op2_d;
    logic [XLEN-1:0]   ex_imm_q,   ex_imm_d;
    logic [4:0]        ex_rs1_q,   ex_rs1_d;
    logic [4:0]        ex_rs2_q,   ex_rs2_d;
    logic [4:0]        ex_rd_q,    ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [XLEN-1:0]   op1_s;
    logic [XLEN-1:0]   op2_s;
    logic              haz_s;
    logic              stall_s;

    // x0 reads as zero; write-back to x0 is never bypassed.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_we,
        input logic [4:0]      wb_idx,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] r;
        if (rs == 5'd0) begin
            r = '0;
        end else if (wb_we && (wb_idx != 5'd0) && (wb_idx == rs)) begin
            r = wb_val;
        end else begin
            r = rf_data;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Operand bypass and load-use hazard detection.
    always_comb begin
        op1_s = sel_operand(bus.id_rs1, bus.ReadData1, bus.wb_regwrite, bus.wb_rd, bus.wb_data);
        op2_s = sel_operand(bus.id_rs2, bus.ReadData2, bus.wb_regwrite, bus.wb_rd, bus.wb_data);
        haz_s = ex_valid_q && ex_ctrl_q[CTRL_MEMREAD] && (ex_rd_q != 5'd0) && bus.id_valid
                && ((ex_rd_q == bus.id_rs1) || (ex_rd_q == bus.id_rs2));
        stall_s = haz_s && !bus.flush;
    end

    // Next-state selection: flush beats stall beats advance; both kill paths load a bubble.
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_pc_d     = '0;
        ex_op1_d    = '0;
        ex_op2_d    = '0;
        ex_imm_d    = '0;
        ex_rs1_d    = 5'd0;
        ex_rs2_d    = 5'd0;
        ex_rd_d     = 5'd0;
        ex_ctrl_d   = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.flush) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (haz_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            ex_valid_d = bus.id_valid;
            ex_pc_d    = bus.id_pc;
            ex_op1_d   = op1_s;
            ex_op2_d   = op2_s;
            ex_imm_d   = bus.id_imm;
            ex_rs1_d   = bus.id_rs1;
            ex_rs2_d   = bus.id_rs2;
            ex_rd_d    = bus.id_rd;
            if (bus.id_valid) begin
                ex_ctrl_d = bus.id_ctrl;
            end else begin
                ex_ctrl_d = '0;
            end
        end
    end

    // ID/EX register and counters; reset discards any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= '0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            ex_imm_q    <= '0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            ex_rd_q     <= 5'd0;
            ex_ctrl_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_pc_q     <= ex_pc_d;
            ex_op1_q    <= ex_op1_d;
            ex_op2_q    <= ex_op2_d;
            ex_imm_q    <= ex_imm_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            ex_ctrl_q   <= ex_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall       = stall_s;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_op1      = ex_op1_q;
    assign bus.ex_op2      = ex_op2_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs1      = ex_rs1_q;
    assign bus.ex_rs2      = ex_rs2_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ID/EX contents are queued at drive time
// and compared one cycle later; a narrow-counter instance covers saturation.
module tb_id_ex_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_ex_stage_if #(.XLEN(64), .CTRL_W(8), .CNT_W(32)) bus ();
    id_ex_stage_if #(.XLEN(64), .CTRL_W(8), .CNT_W(2))  sbus ();

    id_ex_stage #(.XLEN(64), .CTRL_W(8), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    id_ex_stage #(.XLEN(64), .CTRL_W(8), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus.slave)
    );

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb_q[$];
    logic        m_valid;
    logic [7:0]  m_ctrl;
    logic [4:0]  m_rd;
    logic [31:0] m_sc;
    logic [31:0] m_fc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_op(input logic [4:0] rs, input logic [63:0] rf,
                                           input logic we, input logic [4:0] wrd,
                                           input logic [63:0] wd);
        if (rs == 5'd0) return 64'd0;
        if (we && wrd == rs && wrd != 5'd0) return wd;
        return rf;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.valid = bus.ex_valid; o.pc = bus.ex_pc; o.op1 = bus.ex_op1; o.op2 = bus.ex_op2;
        o.imm = bus.ex_imm; o.rs1 = bus.ex_rs1; o.rs2 = bus.ex_rs2; o.rd = bus.ex_rd;
        o.ctrl = bus.ex_ctrl; o.sc = bus.stall_count; o.fc = bus.flush_count;
        return o;
    endfunction

    // Drives one decode cycle, checks stall, queues the expectation, then pops and compares.
    task automatic drive(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] imm,
                         input logic [7:0] ctrl, input logic [63:0] rd1, input logic [63:0] rd2,
                         input logic we, input logic [4:0] wrd, input logic [63:0] wd,
                         input logic fl, input string name);
        exp_t e;
        exp_t got;
        logic haz;
        bus.id_valid = v; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_imm = imm; bus.id_ctrl = ctrl; bus.ReadData1 = rd1; bus.ReadData2 = rd2;
        bus.wb_regwrite = we; bus.wb_rd = wrd; bus.wb_data = wd; bus.flush = fl;
        #1;
        haz = m_valid && m_ctrl[6] && (m_rd != 5'd0) && v && (m_rd == rs1 || m_rd == rs2);
        checks++;
        if (bus.stall !== (haz && !fl)) begin
            errors++;
            $display("FAIL %s stall got %b exp %b", name, bus.stall, haz && !fl);
        end
        e = '0;
        if (fl) begin
            e.sc = m_sc;
            e.fc = (&m_fc) ? m_fc : m_fc + 32'd1;
        end else if (haz) begin
            e.sc = (&m_sc) ? m_sc : m_sc + 32'd1;
            e.fc = m_fc;
        end else begin
            e.valid = v; e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
            e.op1 = ref_op(rs1, rd1, we, wrd, wd);
            e.op2 = ref_op(rs2, rd2, we, wrd, wd);
            e.ctrl = v ? ctrl : 8'd0;
            e.sc = m_sc; e.fc = m_fc;
        end
        sb_q.push_back(e);
        m_valid = e.valid; m_ctrl = e.ctrl; m_rd = e.rd; m_sc = e.sc; m_fc = e.fc;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        got = observed();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s ex got %h exp %h", name, got, e);
        end
    endtask

    task automatic idle_inputs();
        bus.id_valid = 1'b0; bus.id_pc = 64'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_rd = 5'd0; bus.id_imm = 64'd0; bus.id_ctrl = 8'd0; bus.ReadData1 = 64'd0;
        bus.ReadData2 = 64'd0; bus.wb_regwrite = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 64'd0;
        bus.flush = 1'b0;
        sbus.id_valid = 1'b0; sbus.id_pc = 64'd0; sbus.id_rs1 = 5'd0; sbus.id_rs2 = 5'd0;
        sbus.id_rd = 5'd0; sbus.id_imm = 64'd0; sbus.id_ctrl = 8'd0; sbus.ReadData1 = 64'd0;
        sbus.ReadData2 = 64'd0; sbus.wb_regwrite = 1'b0; sbus.wb_rd = 5'd0;
        sbus.wb_data = 64'd0; sbus.flush = 1'b0;
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_ctrl = 8'd0; m_rd = 5'd0; m_sc = 32'd0; m_fc = 32'd0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        exp_t got;
        idle_inputs();
        model_clear();
        reset = 1'b0;
        #12;
        got = observed();
        checks++;
        if (got !== exp_t'(0)) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", got);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_advance();
        drive(1'b1, 64'h100, 5'd5, 5'd6, 5'd9, 64'hFFFF_FFFF_FFFF_FFFC, 8'h80,
              64'h10, 64'h20, 1'b0, 5'd0, 64'd0, 1'b0, "advance");
        checks++;
        if (bus.ex_op1 !== 64'h10 || bus.ex_op2 !== 64'h20 ||
            bus.ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL advance_const got %h %h %h %b exp 10 20 fffffffffffffffc 1",
                     bus.ex_op1, bus.ex_op2, bus.ex_imm, bus.ex_valid);
        end
        drive(1'b0, 64'h104, 5'd1, 5'd2, 5'd3, 64'd7, 8'hFF,
              64'h5, 64'h6, 1'b0, 5'd0, 64'd0, 1'b0, "invalid_ctrl_zero");
    endtask

    task automatic test_bypass();
        drive(1'b1, 64'h200, 5'd5, 5'd6, 5'd10, 64'd1, 8'h80,
              64'h10, 64'h20, 1'b1, 5'd5, 64'hAB, 1'b0, "bypass_rs1");
        checks++;
        if (bus.ex_op1 !== 64'hAB) begin
            errors++;
            $display("FAIL bypass_rs1_const got %h exp ab", bus.ex_op1);
        end
        drive(1'b1, 64'h204, 5'd0, 5'd6, 5'd10, 64'd1, 8'h80,
              64'h10, 64'h20, 1'b1, 5'd0, 64'hAB, 1'b0, "bypass_x0");
        checks++;
        if (bus.ex_op1 !== 64'd0) begin
            errors++;
            $display("FAIL bypass_x0_const got %h exp 0", bus.ex_op1);
        end
        drive(1'b1, 64'h208, 5'd3, 5'd4, 5'd10, 64'd1, 8'h80,
              64'h33, 64'h44, 1'b1, 5'd4, 64'hCD, 1'b0, "bypass_rs2");
        drive(1'b1, 64'h20C, 5'd3, 5'd4, 5'd10, 64'd1, 8'h80,
              64'h33, 64'h44, 1'b0, 5'd3, 64'hEE, 1'b0, "no_bypass_we0");
    endtask

    task automatic test_load_use();
        drive(1'b1, 64'h300, 5'd2, 5'd3, 5'd7, 64'd8, 8'hC0,
              64'h1, 64'h2, 1'b0, 5'd0, 64'd0, 1'b0, "ld_issue");
        drive(1'b1, 64'h304, 5'd1, 5'd7, 5'd8, 64'd0, 8'h80,
              64'h11, 64'h22, 1'b0, 5'd0, 64'd0, 1'b0, "lu_stall");
        checks++;
        if (bus.ex_ctrl !== 8'd0 || bus.stall_count !== 32'd1) begin
            errors++;
            $display("FAIL lu_bubble got ctrl %h cnt %0d exp ctrl 0 cnt 1",
                     bus.ex_ctrl, bus.stall_count);
        end
        drive(1'b1, 64'h304, 5'd1, 5'd7, 5'd8, 64'd0, 8'h80,
              64'h11, 64'h22, 1'b1, 5'd7, 64'h77, 1'b0, "lu_resume");
    endtask

    task automatic test_flush_vs_stall();
        drive(1'b1, 64'h400, 5'd2, 5'd3, 5'd9, 64'd8, 8'hC0,
              64'h1, 64'h2, 1'b0, 5'd0, 64'd0, 1'b0, "ld2_issue");
        drive(1'b1, 64'h404, 5'd9, 5'd1, 5'd4, 64'd0, 8'h80,
              64'h1, 64'h2, 1'b0, 5'd0, 64'd0, 1'b1, "flush_over_stall");
        checks++;
        if (bus.flush_count !== 32'd1 || bus.stall_count !== 32'd1) begin
            errors++;
            $display("FAIL flush_counts got f %0d s %0d exp f 1 s 1",
                     bus.flush_count, bus.stall_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 64'($urandom), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  1'($urandom_range(0, 7) == 0), "random");
        end
    endtask

    task automatic test_reset_midrun();
        exp_t got;
        drive(1'b1, 64'h500, 5'd1, 5'd2, 5'd3, 64'd5, 8'hE0,
              64'h9, 64'hA, 1'b0, 5'd0, 64'd0, 1'b0, "pre_reset");
        reset = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== exp_t'(0)) begin
            errors++;
            $display("FAIL reset_midrun got %h exp 0", got);
        end
        idle_inputs();
        model_clear();
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 64'h600, 5'd1, 5'd2, 5'd3, 64'd5, 8'h80,
              64'h9, 64'hA, 1'b0, 5'd0, 64'd0, 1'b0, "post_reset");
    endtask

    task automatic test_saturation();
        logic [1:0] exp_fc;
        exp_fc = 2'd0;
        sbus.flush = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            exp_fc = (&exp_fc) ? exp_fc : exp_fc + 2'd1;
            checks++;
            if (sbus.flush_count !== exp_fc || sbus.ex_valid !== 1'b0) begin
                errors++;
                $display("FAIL saturation got %0d exp %0d", sbus.flush_count, exp_fc);
            end
        end
        sbus.flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_advance();
        test_bypass();
        test_load_use();
        test_flush_vs_stall();
        test_back_to_back();
        test_reset_midrun();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
